serial_bit_feeder: RTL and testbench

- Parallel-to-serial stage that sits directly upstream of the serial-input FSMs (the Moore and Mealy sequence detectors).
- Accepts WIDTH-bit words from the byte-operation stage through a valid/ready handshake, buffers one word, and shifts it out one bit per enabled cycle.
- Outputs are a bit stream with per-bit valid, a last-bit marker and a count of completed words.
- The detector's `data`/`in` input connects to bit_out.

---
 rtl/serial_bit_feeder_if.sv | 23 ++
 rtl/serial_bit_feeder.sv | 153 +++++++++++++++
 tb/tb_serial_bit_feeder.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/serial_bit_feeder_if.sv
// Handshake bundle for serial_bit_feeder: word intake from the byte stage and
// the per-bit stream towards the serial-input detectors.
interface serial_bit_feeder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  logic             bit_en;
  logic             bit_out;
  logic             bit_valid;
  logic             bit_last;

  modport master (
    output in_data, in_valid, bit_en,
    input  in_ready, bit_out, bit_valid, bit_last
  );

  modport slave (
    input  in_data, in_valid, bit_en,
    output in_ready, bit_out, bit_valid, bit_last
  );
endinterface

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial feeder: one-entry pending buffer, shifter and optional
// inter-word gap; every stream output comes straight from a flop.
module serial_bit_feeder #(
  parameter int WIDTH      = 8,
  parameter int MSB_FIRST  = 1,
  parameter int GAP_CYCLES = 1
) (
  input  logic               clk,
  input  logic               reset,
  serial_bit_feeder_if.slave sif,
  output logic               busy,
  output logic [7:0]         word_count
);

  localparam int             CW       = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST_IDX = CW'(WIDTH - 1);
  localparam logic [3:0]     GAP_LAST = 4'((GAP_CYCLES > 0) ? (GAP_CYCLES - 1) : 0);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [WIDTH-1:0] pend_r, pend_s;
  logic             pend_full_r, pend_full_s;
  logic [WIDTH-1:0] shift_r, shift_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [3:0]       gap_r, gap_s;
  logic [7:0]       word_count_r, word_count_s;
  logic             load_s;
  logic             accept_s;

  logic             bit_out_r, bit_valid_r, bit_last_r, in_ready_r, busy_r;

  function automatic logic head_bit(input logic [WIDTH-1:0] w);
    if (MSB_FIRST != 0) return w[WIDTH-1];
    else                return w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    if (MSB_FIRST != 0) return {w[WIDTH-2:0], 1'b0};
    else                return {1'b0, w[WIDTH-1:1]};
  endfunction

  // Next-state, buffer and counter decode; load and accept never coincide
  // because a load needs a full buffer and an accept needs an empty one.
  always_comb begin
    state_s      = state_r;
    pend_s       = pend_r;
    pend_full_s  = pend_full_r;
    shift_s      = shift_r;
    cnt_s        = cnt_r;
    gap_s        = gap_r;
    word_count_s = word_count_r;
    load_s       = 1'b0;
    accept_s     = sif.in_valid && in_ready_r;

    case (state_r)
      IDLE: begin
        if (pend_full_r) load_s  = 1'b1;
        else             state_s = IDLE;
      end
      SHIFT: begin
        if (sif.bit_en) begin
          if (cnt_r == LAST_IDX) begin
            word_count_s = word_count_r + 8'd1;
            if (GAP_CYCLES > 0) begin
              state_s = GAP;
              gap_s   = 4'd0;
            end else if (pend_full_r) begin
              load_s  = 1'b1;
            end else begin
              state_s = IDLE;
            end
          end else begin
            shift_s = advance(shift_r);
            cnt_s   = cnt_r + CW'(1);
          end
        end else begin
          state_s = SHIFT;
        end
      end
      GAP: begin
        if (gap_r == GAP_LAST) begin
          if (pend_full_r) load_s  = 1'b1;
          else             state_s = IDLE;
        end else begin
          gap_s = gap_r + 4'd1;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    if (load_s) begin
      state_s     = SHIFT;
      shift_s     = pend_r;
      cnt_s       = '0;
      pend_full_s = 1'b0;
    end else begin
      shift_s     = shift_s;
    end

    if (accept_s) begin
      pend_s      = sif.in_data;
      pend_full_s = 1'b1;
    end else begin
      pend_s      = pend_r;
    end
  end

  // State, datapath and output flops; outputs are precomputed from next state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      pend_r       <= '0;
      pend_full_r  <= 1'b0;
      shift_r      <= '0;
      cnt_r        <= '0;
      gap_r        <= 4'd0;
      word_count_r <= 8'd0;
      bit_out_r    <= 1'b0;
      bit_valid_r  <= 1'b0;
      bit_last_r   <= 1'b0;
      in_ready_r   <= 1'b1;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_s;
      pend_r       <= pend_s;
      pend_full_r  <= pend_full_s;
      shift_r      <= shift_s;
      cnt_r        <= cnt_s;
      gap_r        <= gap_s;
      word_count_r <= word_count_s;
      bit_out_r    <= (state_s == SHIFT) ? head_bit(shift_s) : 1'b0;
      bit_valid_r  <= (state_s == SHIFT);
      bit_last_r   <= (state_s == SHIFT) && (cnt_s == LAST_IDX);
      in_ready_r   <= !pend_full_s;
      busy_r       <= (state_s != IDLE) || pend_full_s;
    end
  end

  assign sif.in_ready  = in_ready_r;
  assign sif.bit_out   = bit_out_r;
  assign sif.bit_valid = bit_valid_r;
  assign sif.bit_last  = bit_last_r;
  assign busy          = busy_r;
  assign word_count    = word_count_r;

endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed bench for serial_bit_feeder: three configurations share clock/reset.
module tb_serial_bit_feeder;

  logic       clk;
  logic       reset;
  logic       busy_a, busy_b, busy_c;
  logic [7:0] wc_a, wc_b, wc_c;
  int         checks = 0;
  int         errors = 0;

  serial_bit_feeder_if #(.WIDTH(8)) if_a ();
  serial_bit_feeder_if #(.WIDTH(8)) if_b ();
  serial_bit_feeder_if #(.WIDTH(8)) if_c ();

  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1), .GAP_CYCLES(1)) u_a (
    .clk(clk), .reset(reset), .sif(if_a), .busy(busy_a), .word_count(wc_a));
  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(1), .GAP_CYCLES(0)) u_b (
    .clk(clk), .reset(reset), .sif(if_b), .busy(busy_b), .word_count(wc_b));
  serial_bit_feeder #(.WIDTH(8), .MSB_FIRST(0), .GAP_CYCLES(1)) u_c (
    .clk(clk), .reset(reset), .sif(if_c), .busy(busy_c), .word_count(wc_c));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  initial begin
    logic [7:0]  w;
    logic [15:0] w16;
    int          cyc;
    int          sent;
    logic        accepting;

    reset = 1'b0;
    if_a.in_data = 8'h00; if_a.in_valid = 1'b0; if_a.bit_en = 1'b1;
    if_b.in_data = 8'h00; if_b.in_valid = 1'b0; if_b.bit_en = 1'b1;
    if_c.in_data = 8'h00; if_c.in_valid = 1'b0; if_c.bit_en = 1'b1;

    // Asynchronous reset, no clock edge in between
    #3 reset = 1'b1;
    #1;
    chk("rst_in_ready",  {31'd0, if_a.in_ready},  32'd1);
    chk("rst_bit_valid", {31'd0, if_a.bit_valid}, 32'd0);
    chk("rst_bit_out",   {31'd0, if_a.bit_out},   32'd0);
    chk("rst_bit_last",  {31'd0, if_a.bit_last},  32'd0);
    chk("rst_busy",      {31'd0, busy_a},         32'd0);
    chk("rst_wc",        {24'd0, wc_a},           32'd0);
    step();
    step();
    reset = 1'b0;

    // Single word 0xA5, MSB first, one gap cycle
    w = 8'hA5;
    if_a.in_data = w; if_a.in_valid = 1'b1;
    step();
    if_a.in_valid = 1'b0;
    chk("sw_pend_ready", {31'd0, if_a.in_ready},  32'd0);
    chk("sw_pend_busy",  {31'd0, busy_a},         32'd1);
    chk("sw_pend_valid", {31'd0, if_a.bit_valid}, 32'd0);
    step();
    for (int i = 0; i < 8; i++) begin
      chk("sw_valid", {31'd0, if_a.bit_valid}, 32'd1);
      chk("sw_bit",   {31'd0, if_a.bit_out},   {31'd0, w[7-i]});
      chk("sw_last",  {31'd0, if_a.bit_last},  (i == 7) ? 32'd1 : 32'd0);
      step();
    end
    chk("sw_gap_valid", {31'd0, if_a.bit_valid}, 32'd0);
    chk("sw_gap_busy",  {31'd0, busy_a},         32'd1);
    chk("sw_gap_wc",    {24'd0, wc_a},           32'd1);
    step();
    chk("sw_idle_busy", {31'd0, busy_a},         32'd0);
    chk("sw_idle_wc",   {24'd0, wc_a},           32'd1);

    // Back-to-back 0x0F, 0xF0 with no gap
    w16 = 16'h0FF0;
    if_b.in_data = 8'h0F; if_b.in_valid = 1'b1;
    step();
    chk("bb_ready_full", {31'd0, if_b.in_ready},  32'd0);
    chk("bb_pre_valid",  {31'd0, if_b.bit_valid}, 32'd0);
    if_b.in_data = 8'hF0;
    step();
    for (int i = 0; i < 16; i++) begin
      chk("bb_valid", {31'd0, if_b.bit_valid}, 32'd1);
      chk("bb_bit",   {31'd0, if_b.bit_out},   {31'd0, w16[15-i]});
      chk("bb_ready", {31'd0, if_b.in_ready},  (i == 0 || i >= 8) ? 32'd1 : 32'd0);
      if (i == 1) if_b.in_valid = 1'b0;
      step();
    end
    chk("bb_end_valid", {31'd0, if_b.bit_valid}, 32'd0);
    chk("bb_end_busy",  {31'd0, busy_b},         32'd0);
    chk("bb_end_wc",    {24'd0, wc_b},           32'd2);

    // LSB first with bit_en alternating 0/1
    w = 8'h01;
    if_c.in_data = w; if_c.in_valid = 1'b1;
    step();
    if_c.in_valid = 1'b0;
    step();
    for (int j = 0; j < 16; j++) begin
      chk("ls_valid", {31'd0, if_c.bit_valid}, 32'd1);
      chk("ls_bit",   {31'd0, if_c.bit_out},   {31'd0, w[j/2]});
      chk("ls_last",  {31'd0, if_c.bit_last},  (j >= 14) ? 32'd1 : 32'd0);
      if_c.bit_en = (j % 2 == 1);
      step();
    end
    if_c.bit_en = 1'b1;
    chk("ls_end_valid", {31'd0, if_c.bit_valid}, 32'd0);
    chk("ls_end_wc",    {24'd0, wc_c},           32'd1);

    // Reset in the middle of 0xC3 with 0x3C pending
    w = 8'hC3;
    if_a.in_data = w; if_a.in_valid = 1'b1;
    step();
    if_a.in_data = 8'h3C;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("rm_bit", {31'd0, if_a.bit_out}, {31'd0, w[7-i]});
      step();
      if_a.in_valid = 1'b0;
    end
    chk("rm_pend_busy", {31'd0, busy_a}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rm_rst_valid", {31'd0, if_a.bit_valid}, 32'd0);
    chk("rm_rst_ready", {31'd0, if_a.in_ready},  32'd1);
    chk("rm_rst_busy",  {31'd0, busy_a},         32'd0);
    chk("rm_rst_wc",    {24'd0, wc_a},           32'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("rm_quiet", {30'd0, if_a.bit_valid, busy_a}, 32'd0);
      step();
    end
    w = 8'h81;
    if_a.in_data = w; if_a.in_valid = 1'b1;
    step();
    if_a.in_valid = 1'b0;
    step();
    for (int i = 0; i < 8; i++) begin
      chk("rm_new_valid", {31'd0, if_a.bit_valid}, 32'd1);
      chk("rm_new_bit",   {31'd0, if_a.bit_out},   {31'd0, w[7-i]});
      step();
    end
    chk("rm_new_wc", {24'd0, wc_a}, 32'd1);

    // Counter wrap on the gapless instance (its counter was cleared above)
    if_b.in_valid = 1'b1;
    sent = 0;
    cyc  = 0;
    while (sent < 256 && cyc < 6000) begin
      if_b.in_data = 8'(sent);
      accepting = if_b.in_ready;
      step();
      cyc++;
      if (accepting) sent++;
    end
    if_b.in_valid = 1'b0;
    chk("wr_sent", sent, 32'd256);
    cyc = 0;
    while (busy_b !== 1'b0 && cyc < 200) begin
      step();
      cyc++;
    end
    chk("wr_drain", {31'd0, busy_b}, 32'd0);
    chk("wr_wc_256", {24'd0, wc_b}, 32'd0);
    if_b.in_data = 8'h5A; if_b.in_valid = 1'b1;
    step();
    if_b.in_valid = 1'b0;
    cyc = 0;
    while (busy_b !== 1'b0 && cyc < 200) begin
      step();
      cyc++;
    end
    chk("wr_drain_257", {31'd0, busy_b}, 32'd0);
    chk("wr_wc_257", {24'd0, wc_b}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
